// File: rtl/video_spot_tracker.sv
// Per-frame bright-spot statistics (count, coordinate sums, bounding box) with a 1-cycle processed video path.
// Optional SPOT_CENTROID_EN adds a shared serial restoring divider producing the centroid.
module video_spot_tracker #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int MIN_PIX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [7:0]           threshold,
    input  logic                 video_frame_valid,
    input  logic                 video_line_valid,
    input  logic                 video_data_valid,
    input  logic [7:0]           video_data_in,
    input  logic [19:0]          video_address,
    output logic [7:0]           video_data_out,
    output logic                 video_valid_out,
    output logic                 result_valid,
    output logic                 spot_found,
    output logic [X_W+Y_W:0]     pix_count,
    output logic [2*X_W+Y_W:0]   sum_x,
    output logic [X_W+2*Y_W:0]   sum_y,
    output logic [X_W-1:0]       bbox_x0,
    output logic [X_W-1:0]       bbox_x1,
    output logic [Y_W-1:0]       bbox_y0,
    output logic [Y_W-1:0]       bbox_y1,
    output logic [X_W-1:0]       cent_x,
    output logic [Y_W-1:0]       cent_y
);

    localparam int CW  = X_W + Y_W + 1;
    localparam int SXW = 2 * X_W + Y_W + 1;
    localparam int SYW = X_W + 2 * Y_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t           state_r;
    logic             fv_d_r;
    logic [7:0]       thr_r;
    logic [CW-1:0]    cnt_r;
    logic [SXW-1:0]   sx_r;
    logic [SYW-1:0]   sy_r;
    logic [X_W-1:0]   x0_r, x1_r;
    logic [Y_W-1:0]   y0_r, y1_r;

    logic [X_W-1:0]   x_s;
    logic [Y_W-1:0]   y_s;
    logic             rise_s, fall_s, bright_s, hit_s, in_box_s, border_s;
    logic [7:0]       thr_eff_s, vid_s;
    logic [CW-1:0]    cnt_b_s, cnt_n_s;
    logic [SXW-1:0]   sx_b_s, sx_n_s;
    logic [SYW-1:0]   sy_b_s, sy_n_s;
    logic [X_W-1:0]   x0_b_s, x1_b_s, x0_n_s, x1_n_s;
    logic [Y_W-1:0]   y0_b_s, y1_b_s, y0_n_s, y1_n_s;

    assign x_s       = video_address[X_W-1:0];
    assign y_s       = video_address[X_W+Y_W-1:X_W];
    assign rise_s    = video_frame_valid & ~fv_d_r;
    assign fall_s    = ~video_frame_valid & fv_d_r;
    // The threshold is latched on the rising edge, so that first cycle must use the live value.
    assign thr_eff_s = rise_s ? threshold : thr_r;
    assign bright_s  = (video_data_in >= thr_eff_s);
    assign hit_s     = video_frame_valid & video_line_valid & video_data_valid & bright_s;

    // Outside ACCUM the next-state accumulators start from the cleared frame values.
    assign cnt_b_s = (state_r == ACCUM) ? cnt_r : {CW{1'b0}};
    assign sx_b_s  = (state_r == ACCUM) ? sx_r  : {SXW{1'b0}};
    assign sy_b_s  = (state_r == ACCUM) ? sy_r  : {SYW{1'b0}};
    assign x0_b_s  = (state_r == ACCUM) ? x0_r  : {X_W{1'b1}};
    assign x1_b_s  = (state_r == ACCUM) ? x1_r  : {X_W{1'b0}};
    assign y0_b_s  = (state_r == ACCUM) ? y0_r  : {Y_W{1'b1}};
    assign y1_b_s  = (state_r == ACCUM) ? y1_r  : {Y_W{1'b0}};

    assign cnt_n_s = hit_s ? cnt_b_s + CW'(1)   : cnt_b_s;
    assign sx_n_s  = hit_s ? sx_b_s + SXW'(x_s) : sx_b_s;
    assign sy_n_s  = hit_s ? sy_b_s + SYW'(y_s) : sy_b_s;
    assign x0_n_s  = (hit_s && (x_s < x0_b_s)) ? x_s : x0_b_s;
    assign x1_n_s  = (hit_s && (x_s > x1_b_s)) ? x_s : x1_b_s;
    assign y0_n_s  = (hit_s && (y_s < y0_b_s)) ? y_s : y0_b_s;
    assign y1_n_s  = (hit_s && (y_s > y1_b_s)) ? y_s : y1_b_s;

    assign in_box_s = (x_s >= bbox_x0) && (x_s <= bbox_x1) && (y_s >= bbox_y0) && (y_s <= bbox_y1);
    assign border_s = spot_found && in_box_s &&
                      ((x_s == bbox_x0) || (x_s == bbox_x1) || (y_s == bbox_y0) || (y_s == bbox_y1));

`ifdef SPOT_CENTROID_EN
    localparam int DW  = (SXW > SYW) ? SXW : SYW;
    localparam int DCW = $clog2(DW) + 1;

    logic [DW-1:0]  sh_r, sh_n_s;
    logic [CW-1:0]  rem_r, rem_n_s;
    logic [CW+1:0]  trial_s;
    logic [DCW-1:0] dcnt_r;
    logic           dsel_r;
    logic [X_W-1:0] cx_r;
    logic [Y_W-1:0] cy_r;

    // Dividend is left-aligned in sh_r; quotient bits shift in from the LSB as dividend bits leave the MSB.
    assign trial_s = {1'b0, rem_r, sh_r[DW-1]} - {2'b00, cnt_r};
    assign rem_n_s = trial_s[CW+1] ? {rem_r[CW-2:0], sh_r[DW-1]} : trial_s[CW-1:0];
    assign sh_n_s  = {sh_r[DW-2:0], ~trial_s[CW+1]};
`else
    assign cent_x = {X_W{1'b0}};
    assign cent_y = {Y_W{1'b0}};
`endif

    // Mode-selected pixel transform
    always_comb begin
        vid_s = video_data_in;
        case (mode)
            2'd0:    vid_s = video_data_in;
            2'd1:    vid_s = bright_s ? 8'hFF : 8'h00;
            2'd2:    vid_s = bright_s ? 8'h00 : 8'hFF;
            2'd3:    vid_s = border_s ? 8'h80 : (bright_s ? 8'hFF : 8'h00);
            default: vid_s = video_data_in;
        endcase
    end

    // Registered video output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            video_data_out  <= 8'h00;
            video_valid_out <= 1'b0;
        end else begin
            video_data_out  <= vid_s;
            video_valid_out <= video_data_valid;
        end
    end

    // Frame FSM: accumulate, optional centroid division, publish results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            fv_d_r       <= 1'b1;   // a frame already in progress at release must not look like a new one
            thr_r        <= 8'h00;
            cnt_r        <= {CW{1'b0}};
            sx_r         <= {SXW{1'b0}};
            sy_r         <= {SYW{1'b0}};
            x0_r         <= {X_W{1'b1}};
            x1_r         <= {X_W{1'b0}};
            y0_r         <= {Y_W{1'b1}};
            y1_r         <= {Y_W{1'b0}};
            result_valid <= 1'b0;
            spot_found   <= 1'b0;
            pix_count    <= {CW{1'b0}};
            sum_x        <= {SXW{1'b0}};
            sum_y        <= {SYW{1'b0}};
            bbox_x0      <= {X_W{1'b0}};
            bbox_x1      <= {X_W{1'b0}};
            bbox_y0      <= {Y_W{1'b0}};
            bbox_y1      <= {Y_W{1'b0}};
`ifdef SPOT_CENTROID_EN
            sh_r         <= {DW{1'b0}};
            rem_r        <= {CW{1'b0}};
            dcnt_r       <= {DCW{1'b0}};
            dsel_r       <= 1'b0;
            cx_r         <= {X_W{1'b0}};
            cy_r         <= {Y_W{1'b0}};
            cent_x       <= {X_W{1'b0}};
            cent_y       <= {Y_W{1'b0}};
`endif
        end else begin
            fv_d_r       <= video_frame_valid;
            result_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        thr_r   <= threshold;
                        cnt_r   <= cnt_n_s;
                        sx_r    <= sx_n_s;
                        sy_r    <= sy_n_s;
                        x0_r    <= x0_n_s;
                        x1_r    <= x1_n_s;
                        y0_r    <= y0_n_s;
                        y1_r    <= y1_n_s;
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    cnt_r <= cnt_n_s;
                    sx_r  <= sx_n_s;
                    sy_r  <= sy_n_s;
                    x0_r  <= x0_n_s;
                    x1_r  <= x1_n_s;
                    y0_r  <= y0_n_s;
                    y1_r  <= y1_n_s;
                    if (fall_s) begin
`ifdef SPOT_CENTROID_EN
                        sh_r    <= DW'(sx_r) << (DW - SXW);
                        rem_r   <= {CW{1'b0}};
                        dcnt_r  <= {DCW{1'b0}};
                        dsel_r  <= 1'b0;
                        state_r <= DIV;
`else
                        state_r <= DONE;
`endif
                    end
                end
`ifdef SPOT_CENTROID_EN
                DIV: begin
                    rem_r  <= rem_n_s;
                    sh_r   <= sh_n_s;
                    dcnt_r <= dcnt_r + DCW'(1);
                    if (!dsel_r && (dcnt_r == DCW'(SXW - 1))) begin
                        cx_r   <= sh_n_s[X_W-1:0];
                        sh_r   <= DW'(sy_r) << (DW - SYW);
                        rem_r  <= {CW{1'b0}};
                        dcnt_r <= {DCW{1'b0}};
                        dsel_r <= 1'b1;
                    end else if (dsel_r && (dcnt_r == DCW'(SYW - 1))) begin
                        cy_r    <= sh_n_s[Y_W-1:0];
                        state_r <= DONE;
                    end
                end
`endif
                DONE: begin
                    pix_count    <= cnt_r;
                    sum_x        <= sx_r;
                    sum_y        <= sy_r;
                    spot_found   <= (cnt_r >= CW'(MIN_PIX));
                    bbox_x0      <= (cnt_r == {CW{1'b0}}) ? {X_W{1'b0}} : x0_r;
                    bbox_x1      <= (cnt_r == {CW{1'b0}}) ? {X_W{1'b0}} : x1_r;
                    bbox_y0      <= (cnt_r == {CW{1'b0}}) ? {Y_W{1'b0}} : y0_r;
                    bbox_y1      <= (cnt_r == {CW{1'b0}}) ? {Y_W{1'b0}} : y1_r;
`ifdef SPOT_CENTROID_EN
                    cent_x       <= (cnt_r == {CW{1'b0}}) ? {X_W{1'b0}} : cx_r;
                    cent_y       <= (cnt_r == {CW{1'b0}}) ? {Y_W{1'b0}} : cy_r;
`endif
                    result_valid <= 1'b1;
                    state_r      <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
